// File: rtl/branch_predictor_if.sv
// Fetch lookup, EX resolution feedback and statistics bundle
// between the core pipeline and the branch predictor.
interface branch_predictor_if #(
   parameter int ADDR_W = 32
);
   logic [ADDR_W-1:0] i_if_pc;
   logic              o_pred_jump;
   logic [ADDR_W-1:0] o_pred_npc;
   logic              i_upd_valid;
   logic [ADDR_W-1:0] i_upd_pc;
   logic              i_upd_taken;
   logic [ADDR_W-1:0] i_upd_target;
   logic              i_upd_mispred;
   logic [31:0]       o_stat_branches;
   logic [31:0]       o_stat_mispred;

   modport master (
      output i_if_pc,
      input  o_pred_jump,
      input  o_pred_npc,
      output i_upd_valid,
      output i_upd_pc,
      output i_upd_taken,
      output i_upd_target,
      output i_upd_mispred,
      input  o_stat_branches,
      input  o_stat_mispred
   );

   modport slave (
      input  i_if_pc,
      output o_pred_jump,
      output o_pred_npc,
      input  i_upd_valid,
      input  i_upd_pc,
      input  i_upd_taken,
      input  i_upd_target,
      input  i_upd_mispred,
      output o_stat_branches,
      output o_stat_mispred
   );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped 2-bit counter predictor with tagged BTB and
// branch/mispredict statistics, trained from EX resolution.
module branch_predictor #(
   parameter int ADDR_W = 32,
   parameter int IDX_W  = 4,
   parameter int TAG_W  = ADDR_W - IDX_W - 2
) (
   input logic               clk,
   input logic               rst_n,
   branch_predictor_if.slave bp
);
   localparam int N = 1 << IDX_W;

   logic [N-1:0]      r_valid;
   logic [TAG_W-1:0]  r_tag    [N];
   logic [ADDR_W-1:0] r_target [N];
   logic [1:0]        r_cnt    [N];
   logic [31:0]       r_stat_br;
   logic [31:0]       r_stat_mp;

   logic [IDX_W-1:0]  w_lk_idx;
   logic [TAG_W-1:0]  w_lk_tag;
   logic              w_hit;
   logic [IDX_W-1:0]  w_up_idx;
   logic [TAG_W-1:0]  w_up_tag;
   logic              w_tm;
   logic [1:0]        w_cnt;

   assign w_lk_idx = bp.i_if_pc[IDX_W+1:2];
   assign w_lk_tag = bp.i_if_pc[ADDR_W-1:IDX_W+2];
   assign w_hit    = r_valid[w_lk_idx]
                   && (r_tag[w_lk_idx] == w_lk_tag);

   // Lookup reads registered state only, so a same-cycle update is not seen
   assign bp.o_pred_jump = w_hit && r_cnt[w_lk_idx][1];
   assign bp.o_pred_npc  = bp.o_pred_jump ? r_target[w_lk_idx]
                         : bp.i_if_pc + ADDR_W'(4);

   assign w_up_idx = bp.i_upd_pc[IDX_W+1:2];
   assign w_up_tag = bp.i_upd_pc[ADDR_W-1:IDX_W+2];
   assign w_tm     = r_valid[w_up_idx]
                   && (r_tag[w_up_idx] == w_up_tag);
   assign w_cnt    = r_cnt[w_up_idx];

   assign bp.o_stat_branches = r_stat_br;
   assign bp.o_stat_mispred  = r_stat_mp;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid   <= '0;
         r_stat_br <= '0;
         r_stat_mp <= '0;
         for (int k = 0; k < N; k++) begin
            r_tag[k]    <= '0;
            r_target[k] <= '0;
            r_cnt[k]    <= 2'b01;
         end
      end else if (bp.i_upd_valid) begin
         r_stat_br <= r_stat_br + 32'd1;
         if (bp.i_upd_mispred)
            r_stat_mp <= r_stat_mp + 32'd1;
         if (w_tm) begin
            if (bp.i_upd_taken) begin
               r_cnt[w_up_idx]    <= (w_cnt == 2'b11) ? 2'b11
                                   : w_cnt + 2'd1;
               r_target[w_up_idx] <= bp.i_upd_target;
            end else begin
               r_cnt[w_up_idx]    <= (w_cnt == 2'b00) ? 2'b00
                                   : w_cnt - 2'd1;
            end
         end else if (bp.i_upd_taken) begin
            // Taken miss evicts whatever alias held the slot
            r_valid[w_up_idx]  <= 1'b1;
            r_tag[w_up_idx]    <= w_up_tag;
            r_target[w_up_idx] <= bp.i_upd_target;
            r_cnt[w_up_idx]    <= 2'b10;
         end
      end
   end
endmodule
